// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a 16-bit word count and big-endian program bytes,
// writes packed 32-bit words to consecutive imem addresses and holds the CPU until done.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_BYTES, S_WRITE, S_DONE
  } state_t;

  localparam longint unsigned CAPACITY = (64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR);

  state_t                state_q, state_d;
  logic [15:0]           n_q, n_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [23:0]           word_q, word_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic        xfer;
  logic [15:0] n_len;
  logic        too_big;
  logic        last_word;

  assign xfer      = in_valid & in_ready_q;
  assign n_len     = {n_q[15:8], in_data};
  assign too_big   = 64'(n_len) > CAPACITY;
  assign last_word = (32'(index_q) == (32'(n_q) - 32'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      byte_cnt_q  <= '0;
      index_q     <= '0;
      word_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      byte_cnt_q  <= byte_cnt_d;
      index_q     <= index_d;
      word_q      <= word_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LEN_HI;
      S_LEN_HI: if (xfer) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (n_len == 16'd0 || too_big) state_d = S_DONE;
          else                           state_d = S_BYTES;
        end
      end
      S_BYTES:  if (xfer && byte_cnt_q == 2'd3) state_d = S_WRITE;
      S_WRITE:  state_d = last_word ? S_DONE : S_BYTES;
      S_DONE:   if (start) state_d = S_LEN_HI;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so they line up with state_q.
  always_comb begin
    n_d         = n_q;
    byte_cnt_d  = byte_cnt_q;
    index_d     = index_q;
    word_d      = word_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    error_d     = error_q;
    in_ready_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_BYTES);
    mem_we_d    = (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
    cpu_hold_d  = (state_d != S_DONE);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d        = '0;
          byte_cnt_d = '0;
          index_d    = '0;
          word_d     = '0;
          error_d    = 1'b0;
        end
      end
      S_LEN_HI: if (xfer) n_d[15:8] = in_data;
      S_LEN_LO: begin
        if (xfer) begin
          n_d        = n_len;
          index_d    = '0;
          byte_cnt_d = '0;
          if (too_big) error_d = 1'b1;
        end
      end
      S_BYTES: begin
        if (xfer) begin
          word_d     = {word_q[15:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_wdata_d = {word_q, in_data};
            mem_addr_d  = ADDR_WIDTH'(BASE_ADDR) + index_q;
          end
        end
      end
      S_WRITE: if (!last_word) index_d = index_q + 1'b1;
      default: ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of loads plus hand-written corner sequences;
// imem writes are checked against a scoreboard queue filled as bytes are driven.
module tb_imem_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, cpu_hold, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        exp_err;
    int          nwords;
  } load_vec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t       exp_q[$];
  load_vec_t tbl[5];
  int        compared = 0;
  int        mismatched = 0;
  int        write_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        write_cnt++;
        $display("write addr=0x%0h data=0x%08h", mem_addr, mem_wdata);
        check("in_ready_during_write", 32'(in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(mem_addr), 32'(e.addr));
          check("write_data", mem_wdata, e.data);
        end
      end
    end
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
  endtask

  // Starts and ends just after a rising edge; in_valid is left high.
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !acc; c++) begin
      at_neg();
      acc = in_ready;
      to_pos();
    end
    if (!acc) begin
      compared++;
      mismatched++;
      $display("FAIL byte_accept_timeout: byte 0x%0h in_ready=%0b, required 1", b, in_ready);
    end
  endtask

  task automatic send_word(input int idx, input logic [31:0] w);
    exp_q.push_back({AW'(idx), w});
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    to_pos();
    start = 1'b0;
  endtask

  task automatic do_load(input load_vec_t v);
    int w_before;
    w_before = write_cnt;
    pulse_start();
    at_neg();
    check("start_done_clear", 32'(done), 32'd0);
    check("start_error_clear", 32'(error), 32'd0);
    check("start_cpu_hold", 32'(cpu_hold), 32'd1);
    check("start_in_ready", 32'(in_ready), 32'd1);
    to_pos();
    send_byte(v.n[15:8]);
    send_byte(v.n[7:0]);
    if (v.nwords >= 1) send_word(0, v.w0);
    if (v.nwords >= 2) send_word(1, v.w1);
    in_valid = 1'b0;
    if (v.nwords > 0) begin
      at_neg();
      check("last_write_we", 32'(mem_we), 32'd1);
      check("last_write_done", 32'(done), 32'd0);
      check("last_write_hold", 32'(cpu_hold), 32'd1);
      to_pos();
    end
    at_neg();
    check("load_done", 32'(done), 32'd1);
    check("load_cpu_hold", 32'(cpu_hold), 32'd0);
    check("load_error", 32'(error), 32'(v.exp_err));
    check("load_in_ready", 32'(in_ready), 32'd0);
    check("load_write_count", 32'(write_cnt - w_before), 32'(v.nwords));
    check("load_queue_empty", 32'(exp_q.size()), 32'd0);
    to_pos();
  endtask

  initial begin
    int w_before;
    load_vec_t v;

    tbl[0] = '{16'd2,   32'h20080005, 32'h01095020, 1'b0, 2};
    tbl[1] = '{16'd0,   32'h0,        32'h0,        1'b0, 0};
    tbl[2] = '{16'd1,   32'hDEADBEEF, 32'h0,        1'b0, 1};
    tbl[3] = '{16'd257, 32'h0,        32'h0,        1'b1, 0};
    tbl[4] = '{16'd1,   32'hCAFEF00D, 32'h0,        1'b0, 1};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    at_neg();
    check_reset_values();
    reset = 1'b0;
    to_pos();
    fork
      monitor();
    join_none

    for (int i = 0; i < 5; i++) do_load(tbl[i]);

    // in_valid held high through WRITE: the byte after the word must stay unconsumed
    w_before = write_cnt;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(0, 32'h12345678);
    in_data = 8'hAA;
    at_neg();
    check("cont_we", 32'(mem_we), 32'd1);
    check("cont_ready_write", 32'(in_ready), 32'd0);
    to_pos();
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check("cont_ready_done", 32'(in_ready), 32'd0);
      check("cont_done", 32'(done), 32'd1);
      to_pos();
    end
    in_valid = 1'b0;
    check("cont_write_count", 32'(write_cnt - w_before), 32'd1);

    // Reset in the middle of word 1 of a 3-word load
    w_before = write_cnt;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(0, 32'h11223344);
    send_byte(8'h55);
    send_byte(8'h66);
    in_valid = 1'b0;
    reset = 1'b1;
    to_pos();
    at_neg();
    check_reset_values();
    reset = 1'b0;
    to_pos();
    check("midreset_write_count", 32'(write_cnt - w_before), 32'd1);
    check("midreset_queue_empty", 32'(exp_q.size()), 32'd0);
    v = '{16'd1, 32'hAABBCCDD, 32'h0, 1'b0, 1};
    do_load(v);

    // start pulsed during BYTES is ignored
    w_before = write_cnt;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(0, 32'h0BADC0DE);
    exp_q.push_back({AW'(1), 32'h76543210});
    send_byte(8'h76);
    send_byte(8'h54);
    in_valid = 1'b0;
    pulse_start();
    at_neg();
    check("start_ignored_done", 32'(done), 32'd0);
    check("start_ignored_ready", 32'(in_ready), 32'd1);
    to_pos();
    send_byte(8'h32);
    send_byte(8'h10);
    in_valid = 1'b0;
    repeat (2) to_pos();
    at_neg();
    check("start_ignored_fin", 32'(done), 32'd1);
    check("start_ignored_writes", 32'(write_cnt - w_before), 32'd2);
    to_pos();
    v = '{16'd1, 32'hFEEDFACE, 32'h0, 1'b0, 1};
    do_load(v);

    // N equal to capacity is accepted
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    in_valid = 1'b0;
    at_neg();
    check("cap_error", 32'(error), 32'd0);
    check("cap_done", 32'(done), 32'd0);
    check("cap_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    to_pos();
    reset = 1'b0;
    to_pos();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
